voltage_window_stats: RTL and testbench

//   Downstream data stage after the input voltage converter. Consumes the
//   8-bit converted-voltage sample stream and, over fixed windows of
//   2**LOG2_WIN samples, produces the window average, minimum and maximum.

---
 rtl/voltage_window_stats.sv | 150 +++++++++++++++
 tb/tb_voltage_window_stats.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/voltage_window_stats.sv
// voltage_window_stats
// Windowed statistics over the converted-voltage sample stream. Every
// 2**LOG2_WIN accepted samples produce an average (floor), minimum and
// maximum, presented on a valid/ready output with an over-threshold flag.
// The next window keeps accumulating while a result waits for the consumer.
// If a new result lands on top of an unconsumed one, a sticky overrun flag
// is raised.
module voltage_window_stats #(
    parameter int          LOG2_WIN = 2,
    parameter logic [7:0]  THRESH   = 8'd200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic       clear,
    input  logic       out_ready,
    output logic       stats_valid,
    output logic [7:0] avg_out,
    output logic [7:0] min_out,
    output logic [7:0] max_out,
    output logic       over_thresh,
    output logic       overrun
);

    // The sum is 8 + LOG2_WIN bits wide. A full window of 255s fits, so it
    // cannot overflow within a window.
    localparam int SUM_W = 8 + LOG2_WIN;
    localparam logic [LOG2_WIN-1:0] CNT_ONE  = 1;
    localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

    // The output side is either holding a result or not.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    out_state_t          state_reg, state_next;
    logic                overrun_reg, overrun_next;
    logic                load_result;

    logic [SUM_W-1:0]    sum_reg;
    logic [LOG2_WIN-1:0] count_reg;
    logic [7:0]          run_min_reg, run_max_reg;

    logic [7:0]          avg_reg, min_reg, max_reg;
    logic                over_reg;

    logic                accept;
    logic                complete;
    logic [SUM_W-1:0]    sum_total;
    logic [7:0]          min_total, max_total, avg_total;

    // Statistics including the current sample. These become the result on
    // the sample that closes a window.
    assign accept    = sample_valid & ~clear;
    assign complete  = accept & (count_reg == CNT_LAST);
    assign sum_total = sum_reg + SUM_W'(sample_in);
    assign min_total = (sample_in < run_min_reg) ? sample_in : run_min_reg;
    assign max_total = (sample_in > run_max_reg) ? sample_in : run_max_reg;
    assign avg_total = 8'(sum_total >> LOG2_WIN);

    // Accumulators. They restart on clear or on window completion, so the
    // next window begins without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg     <= '0;
            count_reg   <= '0;
            run_min_reg <= 8'hFF;
            run_max_reg <= 8'h00;
        end else if (clear || complete) begin
            sum_reg     <= '0;
            count_reg   <= '0;
            run_min_reg <= 8'hFF;
            run_max_reg <= 8'h00;
        end else if (accept) begin
            sum_reg     <= sum_total;
            count_reg   <= count_reg + CNT_ONE;
            run_min_reg <= min_total;
            run_max_reg <= max_total;
        end
    end

    // Output-side state register and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= EMPTY;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            overrun_reg <= overrun_next;
        end
    end

    // Next output state. Clear wins over everything else. A completing
    // window always loads a new result. Overrun is raised only when that
    // result replaces one the consumer has not taken.
    always_comb begin
        state_next   = state_reg;
        overrun_next = overrun_reg;
        load_result  = 1'b0;
        if (clear) begin
            state_next   = EMPTY;
            overrun_next = 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (complete) begin
                        load_result = 1'b1;
                        state_next  = FULL;
                    end
                end
                FULL: begin
                    if (complete) begin
                        load_result = 1'b1;
                        if (!out_ready) begin
                            overrun_next = 1'b1;
                        end
                    end else if (out_ready) begin
                        state_next = EMPTY;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // Result registers. They hold steady until the next window completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_reg  <= 8'h00;
            min_reg  <= 8'h00;
            max_reg  <= 8'h00;
            over_reg <= 1'b0;
        end else if (load_result) begin
            avg_reg  <= avg_total;
            min_reg  <= min_total;
            max_reg  <= max_total;
            over_reg <= (avg_total > THRESH);
        end
    end

    assign stats_valid = (state_reg == FULL);
    assign avg_out     = avg_reg;
    assign min_out     = min_reg;
    assign max_out     = max_reg;
    assign over_thresh = over_reg & stats_valid;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_voltage_window_stats.sv
// tb_voltage_window_stats
// Scoreboard bench. Each stimulus cycle also steps a behavioural model.
// When the model sees a window close, it queues the expected result. The
// entry is popped and compared right after the clock edge on which the DUT
// must present it. Valid, overrun and threshold flags are checked every cycle.
module tb_voltage_window_stats;

    localparam int WIN = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       clear;
    logic       out_ready;
    logic       stats_valid;
    logic [7:0] avg_out;
    logic [7:0] min_out;
    logic [7:0] max_out;
    logic       over_thresh;
    logic       overrun;

    voltage_window_stats #(
        .LOG2_WIN (2),
        .THRESH   (8'd200)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear        (clear),
        .out_ready    (out_ready),
        .stats_valid  (stats_valid),
        .avg_out      (avg_out),
        .min_out      (min_out),
        .max_out      (max_out),
        .over_thresh  (over_thresh),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int avg;
        int mn;
        int mx;
        int ov;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    int m_sum, m_cnt, m_min, m_max;
    int m_valid, m_ovr, m_avg, m_over;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sum   = 0;
        m_cnt   = 0;
        m_min   = 255;
        m_max   = 0;
        m_valid = 0;
        m_ovr   = 0;
        m_avg   = 0;
        m_over  = 0;
    endtask

    // Drive one cycle of stimulus, step the model, and check after the edge.
    task automatic tick(input logic v, input logic [7:0] d, input logic clr, input logic rdy);
        exp_t e;
        int   consumed;
        int   done;
        sample_valid = v;
        sample_in    = d;
        clear        = clr;
        out_ready    = rdy;
        if (clr) begin
            m_sum   = 0;
            m_cnt   = 0;
            m_min   = 255;
            m_max   = 0;
            m_valid = 0;
            m_ovr   = 0;
        end else begin
            consumed = m_valid && rdy;
            done     = 0;
            if (v) begin
                m_sum = m_sum + int'(d);
                if (int'(d) < m_min) m_min = int'(d);
                if (int'(d) > m_max) m_max = int'(d);
                m_cnt++;
                if (m_cnt == WIN) begin
                    done  = 1;
                    e.avg = m_sum / WIN;
                    e.mn  = m_min;
                    e.mx  = m_max;
                    e.ov  = (e.avg > 200) ? 1 : 0;
                    if (m_valid && !rdy) m_ovr = 1;
                    exp_q.push_back(e);
                    m_avg   = e.avg;
                    m_over  = e.ov;
                    m_valid = 1;
                    m_sum   = 0;
                    m_cnt   = 0;
                    m_min   = 255;
                    m_max   = 0;
                end
            end
            if (!done && consumed) m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_eq("stats_valid", 32'(stats_valid), 32'(m_valid));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
        check_eq("over_thresh", 32'(over_thresh), 32'(m_valid && m_over));
        if (m_valid != 0) begin
            check_eq("avg_hold", 32'(avg_out), 32'(m_avg));
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("[TB] result avg=%0d min=%0d max=%0d over=%0b ovr=%0b (exp avg=%0d min=%0d max=%0d)",
                     avg_out, min_out, max_out, over_thresh, overrun, e.avg, e.mn, e.mx);
            check_eq("res_valid", 32'(stats_valid), 32'd1);
            check_eq("res_avg", 32'(avg_out), 32'(e.avg));
            check_eq("res_min", 32'(min_out), 32'(e.mn));
            check_eq("res_max", 32'(max_out), 32'(e.mx));
            check_eq("res_over", 32'(over_thresh), 32'(e.ov));
        end
    endtask

    // Assert rst_n asynchronously between edges and check outputs go to 0 immediately.
    task automatic do_reset();
        sample_valid = 1'b0;
        sample_in    = 8'd0;
        clear        = 1'b0;
        out_ready    = 1'b0;
        rst_n        = 1'b0;
        model_reset();
        #2;
        check_eq("rst_valid", 32'(stats_valid), 32'd0);
        check_eq("rst_avg", 32'(avg_out), 32'd0);
        check_eq("rst_min", 32'(min_out), 32'd0);
        check_eq("rst_max", 32'(max_out), 32'd0);
        check_eq("rst_over", 32'(over_thresh), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] reset applied");
    endtask

    task automatic window4(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d, input logic rdy);
        tick(1'b1, a, 1'b0, rdy);
        tick(1'b1, b, 1'b0, rdy);
        tick(1'b1, c, 1'b0, rdy);
        tick(1'b1, d, 1'b0, rdy);
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 8'd0;
        clear        = 1'b0;
        out_ready    = 1'b0;
        #1;
        do_reset();

        // Basic window with the consumer always ready.
        window4(8'd10, 8'd20, 8'd30, 8'd40, 1'b1);
        check_eq("t1_avg25", 32'(avg_out), 32'd25);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        // Full-scale window, then the accumulators must have restarted.
        window4(8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        window4(8'd0, 8'd1, 8'd2, 8'd3, 1'b1);
        check_eq("t2_avg1", 32'(avg_out), 32'd1);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        // Threshold boundary: exactly 200 is not over, 201 is.
        window4(8'd200, 8'd200, 8'd200, 8'd200, 1'b1);
        tick(1'b0, 8'd0, 1'b0, 1'b1);
        window4(8'd201, 8'd201, 8'd200, 8'd202, 1'b1);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        // Stalled consumer: result held, second window overruns, clear drops it.
        window4(8'd8, 8'd8, 8'd8, 8'd8, 1'b0);
        tick(1'b0, 8'd0, 1'b0, 1'b0);
        window4(8'd4, 8'd4, 8'd4, 8'd4, 1'b0);
        check_eq("t3_overrun", 32'(overrun), 32'd1);
        tick(1'b0, 8'd0, 1'b1, 1'b0);

        // Consume on the same edge the next window completes: no overrun.
        window4(8'd8, 8'd8, 8'd8, 8'd8, 1'b0);
        tick(1'b1, 8'd4, 1'b0, 1'b0);
        tick(1'b1, 8'd4, 1'b0, 1'b0);
        tick(1'b1, 8'd4, 1'b0, 1'b0);
        tick(1'b1, 8'd4, 1'b0, 1'b1);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        // Partial window discarded by clear (sample on the clear cycle ignored), with a gap.
        tick(1'b1, 8'd100, 1'b0, 1'b1);
        tick(1'b1, 8'd100, 1'b0, 1'b1);
        tick(1'b1, 8'd250, 1'b1, 1'b1);
        tick(1'b1, 8'd1, 1'b0, 1'b1);
        tick(1'b0, 8'd99, 1'b0, 1'b1);
        tick(1'b1, 8'd2, 1'b0, 1'b1);
        tick(1'b1, 8'd3, 1'b0, 1'b1);
        tick(1'b1, 8'd4, 1'b0, 1'b1);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        // Partial window discarded by reset.
        tick(1'b1, 8'd50, 1'b0, 1'b1);
        tick(1'b1, 8'd60, 1'b0, 1'b1);
        do_reset();
        window4(8'd5, 8'd5, 8'd5, 8'd5, 1'b1);
        check_eq("t6_avg5", 32'(avg_out), 32'd5);
        tick(1'b0, 8'd0, 1'b0, 1'b1);

        if (exp_q.size() != 0) begin
            check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
